pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipelined control and hazard unit for the 5-stage ARM datapath. Decodes the instruction in Decode and carries its control bits through the E/M/W control registers. Evaluates condition codes against a registered NZCV flags register in Execute. Generates the forwarding selects and the stall/flush signals the datapath consumes.

## Interface
- No parameters.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state on the rising edge of clk
- InstrD  in  32  Decode-stage instruction; uses [31:28] Cond, [27:26] Op, [25:20] Funct, [15:12] Rd
- ALUFlags  in  4  NZCV from the Execute ALU
- Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E  in  1 each  register-address comparisons from the datapath
- RegSrcD, ImmSrcD  out  2 each  Decode selects
- ALUSrcE, MemtoRegE, BranchTakenE  out  1 each
- ALUControlE  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- MemWriteM  out  1
- RegWriteW, MemtoRegW, PCSrcW  out  1 each
- ForwardAE, ForwardBE  out  2 each  00 regfile, 01 ResultW, 10 ALUOutM
- StallF, StallD, FlushD, FlushE  out  1 each

## Operation
- Decoder (combinational on InstrD):
  - Op=00 (DP): RegW=1; ALUSrc=Funct[5]; ImmSrc=00; ALUOp from Funct[4:1] (0100 ADD, 0010 SUB, 0000 AND, 1100 ORR); FlagW[1] (NZ)=Funct[0]; FlagW[0] (CV)=Funct[0] and the op is ADD/SUB.
  - Op=01 (mem): ALUSrc=1, ImmSrc=01, ALU ADD. If Funct[0]=1 (LDR): MemtoReg=1, RegW=1. Otherwise (STR): MemW=1, RegSrc[1]=1.
  - Op=10 (B): Branch=1, ALUSrc=1, ImmSrc=10, RegSrc[0]=1, ALU ADD.
  - Op=11: all controls 0.
- PCSrcD = RegW and Rd==1111.
- Execute stage:
  - CondExE: ARM condition codes 0000–1110 evaluated on the flags register. 1111 evaluates false.
  - RegWrite, MemWrite and PCSrc are gated by CondExE before being registered into M.
  - BranchTakenE = BranchE and CondExE.
- Flags register: updates NZ from ALUFlags[3:2] when FlagW[1]E and CondExE; updates CV from ALUFlags[1:0] when FlagW[0]E and CondExE.
- Forwarding:
  - ForwardAE = 10 if Match_1E_M and RegWriteM; else 01 if Match_1E_W and RegWriteW; else 00.
  - ForwardBE: same rule using the Match_2 signals.
- Hazards:
  - ldrStall = Match_12D_E and MemtoRegE.
  - PCWrPending = PCSrcD or PCSrcE or PCSrcM.
  - StallF = ldrStall or PCWrPending.
  - StallD = ldrStall.
  - FlushD = PCWrPending or PCSrcW or BranchTakenE.
  - FlushE = ldrStall or BranchTakenE.

## Timing
- D→E, E→M and M→W control registers each add 1 cycle. On a flush, a register loads zeros (a bubble).
- On reset, all registered outputs and the flags register are 0. Combinational outputs follow from the zeroed state: Forward 00, stalls/flushes 0.
- Flag update is visible to the condition check of the next instruction in E (no same-cycle bypass).
- Simultaneous ldrStall and BranchTakenE: FlushE wins for E. StallF/StallD still hold the fetch and decode registers. The branch redirect proceeds.
- Reset while a branch or stall is in flight: all pipeline state is cleared, with no partial effects.

## Configuration
- BRANCH_EARLY_EN defined:
  - Branches resolve in E.
  - BranchTakenE drives the PC mux.
  - The branch's PCSrc is not propagated to M/W.
- BRANCH_EARLY_EN undefined:
  - BranchTakenE is held at 0.
  - A taken branch sets PCSrc in E and resolves through PCSrcW like any PC write.
  - Fetch stalls via PCWrPending until the branch reaches W.

## Structure
- Package pipe_ctrl_pkg holds:
  - ALU op codes
  - Op-field encodings
  - condition-code encodings
  - a struct for the per-stage control bundle
- Sub-module cond_unit: flags register plus condition evaluation. All other logic lives in pipe_ctrl_unit.

## Test plan
- ADD R1 followed by SUB using R1: ForwardAE=10 while SUB is in E. With one independent instruction between them: ForwardAE=01.
- LDR R2 followed by ADD using R2: StallF=StallD=FlushE=1 for exactly 1 cycle, then ForwardBE=01.
- SUBS R0,R0,R0 then BEQ (BRANCH_EARLY_EN): BranchTakenE=1 with FlushD=FlushE=1. Repeat with ADDS giving nonzero: BranchTakenE=0.
- ADD with Rd=R15: StallF held through D/E/M, PCSrcW=1 in W, FlushD asserted for 4 cycles.
- MOVNE-style DP with Cond=0001 while Z=1: RegWriteM=0 and MemWriteM=0, flags unchanged.
- Reset asserted mid-stall: the next cycle shows all outputs 0 and flags=0000.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and the per-stage control bundle for pipe_ctrl_unit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    OP_DP   = 2'b00,
    OP_MEM  = 2'b01,
    OP_BR   = 2'b10,
    OP_NONE = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  // Funct[4:1] encodings of the supported data-processing commands
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Control bits carried from Decode into Execute
  typedef struct packed {
    logic       pcsrc;
    logic       regw;
    logic       memtoreg;
    logic       memw;
    logic       branch;
    logic       alusrc;
    alu_op_e    aluctl;
    logic [1:0] flagw;   // [1] NZ, [0] CV
    cond_e      cond;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_ctrl_unit_cond_unit.sv
// NZCV flags register and condition-code evaluation for the Execute stage.
// Flags written here are seen by the next instruction in E, never bypassed.
module cond_unit
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  cond_e      cond,
  input  logic [1:0] flag_w,
  input  logic [3:0] alu_flags,
  output logic       cond_ex
);

  logic [3:0] flags;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags;

  // Evaluate the E-stage condition field against the registered flags
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      CC_EQ: cond_ex = z;
      CC_NE: cond_ex = ~z;
      CC_CS: cond_ex = c;
      CC_CC: cond_ex = ~c;
      CC_MI: cond_ex = n;
      CC_PL: cond_ex = ~n;
      CC_VS: cond_ex = v;
      CC_VC: cond_ex = ~v;
      CC_HI: cond_ex = c & ~z;
      CC_LS: cond_ex = ~c | z;
      CC_GE: cond_ex = (n == v);
      CC_LT: cond_ex = (n != v);
      CC_GT: cond_ex = ~z & (n == v);
      CC_LE: cond_ex = z | (n != v);
      CC_AL: cond_ex = 1'b1;
      CC_NV: cond_ex = 1'b0;
    endcase
  end

  // NZ and CV halves update independently, only for executed instructions
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
    end else begin
      if (flag_w[1] && cond_ex) flags[3:2] <= alu_flags[3:2];
      if (flag_w[0] && cond_ex) flags[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Control and hazard unit for the 5-stage ARM pipeline: decode, E/M/W
// control registers, forwarding selects and stall/flush generation.
// Option: define BRANCH_EARLY_EN to redirect taken branches from Execute;
// otherwise a taken branch travels to W as an ordinary PC write.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [3:0]  ALUFlags,
  input  logic        Match_1E_M,
  input  logic        Match_1E_W,
  input  logic        Match_2E_M,
  input  logic        Match_2E_W,
  input  logic        Match_12D_E,
  output logic [1:0]  RegSrcD,
  output logic [1:0]  ImmSrcD,
  output logic        ALUSrcE,
  output logic        MemtoRegE,
  output logic        BranchTakenE,
  output logic [1:0]  ALUControlE,
  output logic        MemWriteM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        PCSrcW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE
);

  ctrl_t      ctrl_d, ctrl_e;
  logic [3:0] cmd;
  logic       cond_ex, pcsrc_e;
  logic       regw_m, memw_m, memtoreg_m, pcsrc_m;
  logic       ldr_stall, pc_wr_pending;
  logic       unused_instr;

  assign cmd          = InstrD[24:21];
  assign unused_instr = ^{InstrD[19:16], InstrD[11:0]};

  // Main decoder: control bundle and Decode-stage selects from InstrD
  always_comb begin
    ctrl_d  = CTRL_NOP;
    RegSrcD = 2'b00;
    ImmSrcD = 2'b00;
    case (op_e'(InstrD[27:26]))
      OP_DP: begin
        ctrl_d.regw   = 1'b1;
        ctrl_d.alusrc = InstrD[25];
        case (cmd)
          CMD_ADD: ctrl_d.aluctl = ALU_ADD;
          CMD_SUB: ctrl_d.aluctl = ALU_SUB;
          CMD_AND: ctrl_d.aluctl = ALU_AND;
          CMD_ORR: ctrl_d.aluctl = ALU_ORR;
          default: ctrl_d.aluctl = ALU_ADD;
        endcase
        ctrl_d.flagw[1] = InstrD[20];
        ctrl_d.flagw[0] = InstrD[20] & ((cmd == CMD_ADD) | (cmd == CMD_SUB));
      end
      OP_MEM: begin
        ctrl_d.alusrc = 1'b1;
        ctrl_d.aluctl = ALU_ADD;
        ImmSrcD       = 2'b01;
        if (InstrD[20]) begin
          ctrl_d.memtoreg = 1'b1;
          ctrl_d.regw     = 1'b1;
        end else begin
          ctrl_d.memw = 1'b1;
          RegSrcD[1]  = 1'b1;
        end
      end
      OP_BR: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alusrc = 1'b1;
        ctrl_d.aluctl = ALU_ADD;
        ImmSrcD       = 2'b10;
        RegSrcD[0]    = 1'b1;
      end
      default: ;
    endcase
    ctrl_d.cond  = cond_e'(InstrD[31:28]);
    ctrl_d.pcsrc = ctrl_d.regw & (InstrD[15:12] == 4'hF);
  end

  // D->E control register; a flush inserts a bubble
  always_ff @(posedge clk) begin
    if (reset || FlushE) ctrl_e <= CTRL_NOP;
    else                 ctrl_e <= ctrl_d;
  end

  cond_unit u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (ctrl_e.cond),
    .flag_w    (ctrl_e.flagw),
    .alu_flags (ALUFlags),
    .cond_ex   (cond_ex)
  );

`ifdef BRANCH_EARLY_EN
  assign pcsrc_e      = ctrl_e.pcsrc;
  assign BranchTakenE = ctrl_e.branch & cond_ex;
`else
  // Branches ride the PC-write path to W, so they count as a pending PC write
  assign pcsrc_e      = ctrl_e.pcsrc | ctrl_e.branch;
  assign BranchTakenE = 1'b0;
`endif

  assign ALUSrcE     = ctrl_e.alusrc;
  assign MemtoRegE   = ctrl_e.memtoreg;
  assign ALUControlE = ctrl_e.aluctl;

  // E->M register; architectural side effects gated by the condition result
  always_ff @(posedge clk) begin
    if (reset) begin
      regw_m     <= 1'b0;
      memw_m     <= 1'b0;
      memtoreg_m <= 1'b0;
      pcsrc_m    <= 1'b0;
    end else begin
      regw_m     <= ctrl_e.regw & cond_ex;
      memw_m     <= ctrl_e.memw & cond_ex;
      memtoreg_m <= ctrl_e.memtoreg;
      pcsrc_m    <= pcsrc_e & cond_ex;
    end
  end

  assign MemWriteM = memw_m;

  // M->W register
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      PCSrcW    <= 1'b0;
    end else begin
      RegWriteW <= regw_m;
      MemtoRegW <= memtoreg_m;
      PCSrcW    <= pcsrc_m;
    end
  end

  // Forwarding: the younger producer in M takes priority over W
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (Match_1E_M && regw_m)         ForwardAE = 2'b10;
    else if (Match_1E_W && RegWriteW) ForwardAE = 2'b01;
    if (Match_2E_M && regw_m)         ForwardBE = 2'b10;
    else if (Match_2E_W && RegWriteW) ForwardBE = 2'b01;
  end

  // Load-use stall, PC-write fetch hold and branch/PC-write flushes
  always_comb begin
    ldr_stall     = Match_12D_E & ctrl_e.memtoreg;
    pc_wr_pending = ctrl_d.pcsrc | pcsrc_e | pcsrc_m;
    StallF        = ldr_stall | pc_wr_pending;
    StallD        = ldr_stall;
    FlushD        = pc_wr_pending | PCSrcW | BranchTakenE;
    FlushE        = ldr_stall | BranchTakenE;
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: decode table, hand-written hazard
// sequences and randomized traffic against an instruction-level model.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD;
  logic [3:0]  ALUFlags;
  logic        Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic [1:0]  RegSrcD, ImmSrcD, ALUControlE, ForwardAE, ForwardBE;
  logic        ALUSrcE, MemtoRegE, BranchTakenE, MemWriteM;
  logic        RegWriteW, MemtoRegW, PCSrcW, StallF, StallD, FlushD, FlushE;

  pipe_ctrl_unit dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlags(ALUFlags),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W), .Match_12D_E(Match_12D_E),
    .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .MemtoRegE(MemtoRegE),
    .BranchTakenE(BranchTakenE), .ALUControlE(ALUControlE), .MemWriteM(MemWriteM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE)
  );

  always #5 clk = ~clk;

  logic [20:0] obs;
  assign obs = {RegSrcD, ImmSrcD, ALUSrcE, MemtoRegE, BranchTakenE, ALUControlE,
                MemWriteM, RegWriteW, MemtoRegW, PCSrcW, ForwardAE, ForwardBE,
                StallF, StallD, FlushD, FlushE};

  localparam logic [31:0] NOP = 32'hEC00_0000;
  localparam logic [4:0]  M1M = 5'b10000, M1W = 5'b01000, M2M = 5'b00100,
                          M2W = 5'b00010, M12 = 5'b00001;

  int checks = 0, errors = 0;

  // Model: which instruction word sits in E/M/W, whether it executed, flags
  logic        e_v = 0, m_v = 0, w_v = 0, m_ex = 0, w_ex = 0;
  logic [31:0] e_i = 0, m_i = 0, w_i = 0;
  logic [3:0]  flg = 0;

  function automatic logic [31:0] dp(input logic [3:0] c, input logic [3:0] cmd,
                                     input logic s, input logic [3:0] rd, input logic imm);
    return {c, 2'b00, imm, cmd, s, 4'h0, rd, 12'h0};
  endfunction
  function automatic logic [31:0] ldr(input logic [3:0] rd);
    return {4'hE, 2'b01, 6'b011001, 4'h0, rd, 12'h0};
  endfunction
  function automatic logic [31:0] str(input logic [3:0] rd);
    return {4'hE, 2'b01, 6'b011000, 4'h0, rd, 12'h0};
  endfunction
  function automatic logic [31:0] br(input logic [3:0] c);
    return {c, 4'b1010, 24'h0};
  endfunction

  function automatic bit is_dp(input logic [31:0] i);  return i[27:26] == 2'b00; endfunction
  function automatic bit is_ldr(input logic [31:0] i); return i[27:26] == 2'b01 && i[20]; endfunction
  function automatic bit is_str(input logic [31:0] i); return i[27:26] == 2'b01 && !i[20]; endfunction
  function automatic bit is_b(input logic [31:0] i);   return i[27:26] == 2'b10; endfunction
  function automatic bit wr_reg(input logic [31:0] i); return is_dp(i) || is_ldr(i); endfunction
  function automatic bit pc_wr(input logic [31:0] i);  return wr_reg(i) && i[15:12] == 4'hF; endfunction

  function automatic logic [1:0] aluop(input logic [31:0] i);
    if (!is_dp(i)) return 2'b00;
    case (i[24:21])
      4'd2:    return 2'b01;
      4'd0:    return 2'b10;
      4'd12:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction
  function automatic bit alusrc(input logic [31:0] i);
    return is_dp(i) ? i[25] : (i[27:26] == 2'b01 || is_b(i));
  endfunction
  function automatic logic [1:0] immsrc(input logic [31:0] i);
    return is_dp(i) ? 2'b00 : (i[27:26] == 2'b01) ? 2'b01 : is_b(i) ? 2'b10 : 2'b00;
  endfunction

  // ARM condition table over N,Z,C,V
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'd0: return z;         4'd1: return !z;
      4'd2: return cc;        4'd3: return !cc;
      4'd4: return n;         4'd5: return !n;
      4'd6: return v;         4'd7: return !v;
      4'd8: return cc && !z;  4'd9: return !cc || z;
      4'd10: return n == v;   4'd11: return n != v;
      4'd12: return !z && n == v;
      4'd13: return z || n != v;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit pc_write_path(input logic [31:0] i);
`ifdef BRANCH_EARLY_EN
    return pc_wr(i);
`else
    return pc_wr(i) || is_b(i);
`endif
  endfunction

  function automatic bit taken_early();
`ifdef BRANCH_EARLY_EN
    return e_v && is_b(e_i) && cond_ok(e_i[31:28], flg);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [20:0] expect_out();
    bit bt, pce, pcm, pcw, pcd, rwm, rww, ldst, pend;
    logic [1:0] fa, fb;
    bt   = taken_early();
    pce  = e_v && pc_write_path(e_i);
    pcm  = m_v && m_ex && pc_write_path(m_i);
    pcw  = w_v && w_ex && pc_write_path(w_i);
    pcd  = pc_wr(InstrD);
    rwm  = m_v && m_ex && wr_reg(m_i);
    rww  = w_v && w_ex && wr_reg(w_i);
    fa   = (Match_1E_M && rwm) ? 2'b10 : (Match_1E_W && rww) ? 2'b01 : 2'b00;
    fb   = (Match_2E_M && rwm) ? 2'b10 : (Match_2E_W && rww) ? 2'b01 : 2'b00;
    ldst = Match_12D_E && e_v && is_ldr(e_i);
    pend = pcd || pce || pcm;
    return {is_str(InstrD), is_b(InstrD), immsrc(InstrD),
            e_v && alusrc(e_i), e_v && is_ldr(e_i), bt, e_v ? aluop(e_i) : 2'b00,
            m_v && m_ex && is_str(m_i), rww, w_v && is_ldr(w_i), pcw, fa, fb,
            ldst || pend, ldst, pend || pcw || bt, ldst || bt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge and compare against the model
  task automatic cyc(input logic [31:0] ins, input logic [3:0] fl,
                     input logic [4:0] mt, input bit rst);
    @(negedge clk);
    InstrD = ins; ALUFlags = fl; reset = rst;
    {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = mt;
    #1 chk("model", {11'b0, obs}, {11'b0, expect_out()});
  endtask

  // Advance the model across the rising edge using this cycle's inputs
  task automatic adv();
    bit ok, fe;
    @(posedge clk);
    if (reset) begin
      e_v = 0; m_v = 0; w_v = 0; m_ex = 0; w_ex = 0; flg = 4'h0;
    end else begin
      ok = e_v && cond_ok(e_i[31:28], flg);
      fe = (Match_12D_E && e_v && is_ldr(e_i)) || taken_early();
      if (ok && is_dp(e_i) && e_i[20]) begin
        flg[3:2] = ALUFlags[3:2];
        if (e_i[24:21] == 4'd4 || e_i[24:21] == 4'd2) flg[1:0] = ALUFlags[1:0];
      end
      w_v = m_v; w_i = m_i; w_ex = m_ex;
      m_v = e_v; m_i = e_i; m_ex = ok;
      e_v = !fe; e_i = InstrD;
    end
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) begin cyc(NOP, 4'h0, 5'h0, 1'b0); adv(); end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] i;
    i = $urandom;
    if (i[27:26] == 2'b00)
      case ($urandom_range(0, 3))
        0: i[24:21] = 4'd4;
        1: i[24:21] = 4'd2;
        2: i[24:21] = 4'd0;
        default: i[24:21] = 4'd12;
      endcase
    if ($urandom_range(0, 5) == 0) i[15:12] = 4'hF;
    if ($urandom_range(0, 2) == 0) i[31:28] = 4'hE;
    return i;
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic [1:0]  rs, is;
    logic        as;
    logic [1:0]  al;
    logic        mr;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{dp(4'hE, 4'd4, 1'b0, 4'd1, 1'b1), 2'b00, 2'b00, 1'b1, 2'b00, 1'b0};
    tbl[1] = '{dp(4'hE, 4'd2, 1'b0, 4'd2, 1'b0), 2'b00, 2'b00, 1'b0, 2'b01, 1'b0};
    tbl[2] = '{dp(4'hE, 4'd0, 1'b1, 4'd3, 1'b0), 2'b00, 2'b00, 1'b0, 2'b10, 1'b0};
    tbl[3] = '{dp(4'hE, 4'd12, 1'b0, 4'd4, 1'b1), 2'b00, 2'b00, 1'b1, 2'b11, 1'b0};
    tbl[4] = '{ldr(4'd5), 2'b00, 2'b01, 1'b1, 2'b00, 1'b1};
    tbl[5] = '{str(4'd6), 2'b10, 2'b01, 1'b1, 2'b00, 1'b0};
    tbl[6] = '{br(4'hE), 2'b01, 2'b10, 1'b1, 2'b00, 1'b0};
    tbl[7] = '{NOP, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0};

    reset = 1'b1; InstrD = NOP; ALUFlags = 4'h0;
    {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = 5'h0;
    repeat (3) @(posedge clk);
    cyc(NOP, 4'h0, 5'h0, 1'b0);
    chk("reset_state", {11'b0, obs}, 32'h0);
    adv();

    // Decode table: D-stage selects, then E-stage fields one cycle later
    for (int t = 0; t < 8; t++) begin
      cyc(tbl[t].ins, 4'h0, 5'h0, 1'b0);
      chk("dec_regsrc", {30'b0, RegSrcD}, {30'b0, tbl[t].rs});
      chk("dec_immsrc", {30'b0, ImmSrcD}, {30'b0, tbl[t].is});
      adv();
      cyc(NOP, 4'h0, 5'h0, 1'b0);
      chk("e_alusrc", {31'b0, ALUSrcE}, {31'b0, tbl[t].as});
      chk("e_aluctl", {30'b0, ALUControlE}, {30'b0, tbl[t].al});
      chk("e_memtoreg", {31'b0, MemtoRegE}, {31'b0, tbl[t].mr});
      adv();
    end
    nops(4);

    // ADD R1 -> SUB using R1: forward from M
    cyc(dp(4'hE, 4'd4, 1'b0, 4'd1, 1'b1), 4'h0, 5'h0, 1'b0); adv();
    cyc(dp(4'hE, 4'd2, 1'b0, 4'd3, 1'b0), 4'h0, 5'h0, 1'b0); adv();
    cyc(NOP, 4'h0, M1M, 1'b0); chk("fwd_a_m", {30'b0, ForwardAE}, 32'd2); adv();
    nops(3);
    // One independent instruction between: forward from W
    cyc(dp(4'hE, 4'd4, 1'b0, 4'd1, 1'b1), 4'h0, 5'h0, 1'b0); adv();
    cyc(dp(4'hE, 4'd12, 1'b0, 4'd4, 1'b1), 4'h0, 5'h0, 1'b0); adv();
    cyc(dp(4'hE, 4'd2, 1'b0, 4'd3, 1'b0), 4'h0, 5'h0, 1'b0); adv();
    cyc(NOP, 4'h0, M1W, 1'b0); chk("fwd_a_w", {30'b0, ForwardAE}, 32'd1); adv();
    nops(3);

    // LDR R2 -> ADD using R2: one-cycle load-use stall, then forward from W
    cyc(ldr(4'd2), 4'h0, 5'h0, 1'b0); adv();
    cyc(dp(4'hE, 4'd4, 1'b0, 4'd3, 1'b0), 4'h0, M12, 1'b0);
    chk("ldr_stall", {29'b0, StallF, StallD, FlushE}, 32'h7); adv();
    cyc(dp(4'hE, 4'd4, 1'b0, 4'd3, 1'b0), 4'h0, 5'h0, 1'b0);
    chk("ldr_release", {29'b0, StallF, StallD, FlushE}, 32'h0); adv();
    cyc(NOP, 4'h0, M2W, 1'b0); chk("ldr_fwd_b", {30'b0, ForwardBE}, 32'd1); adv();
    nops(3);

    // ADD R15: fetch held through D/E/M, PC write in W, FlushD for 4 cycles
    cyc(dp(4'hE, 4'd4, 1'b0, 4'hF, 1'b1), 4'h0, 5'h0, 1'b0);
    chk("pc_d", {30'b0, StallF, FlushD}, 32'h3); adv();
    cyc(NOP, 4'h0, 5'h0, 1'b0); chk("pc_e", {30'b0, StallF, FlushD}, 32'h3); adv();
    cyc(NOP, 4'h0, 5'h0, 1'b0); chk("pc_m", {30'b0, StallF, FlushD}, 32'h3); adv();
    cyc(NOP, 4'h0, 5'h0, 1'b0); chk("pc_w", {29'b0, PCSrcW, StallF, FlushD}, 32'h5); adv();
    cyc(NOP, 4'h0, 5'h0, 1'b0); chk("pc_done", {30'b0, StallF, FlushD}, 32'h0); adv();

    // SUBS sets Z; ORRNE S is skipped, leaving Z for a following ADDEQ
    cyc(dp(4'hE, 4'd2, 1'b1, 4'd0, 1'b0), 4'h0, 5'h0, 1'b0); adv();
    cyc(dp(4'h1, 4'd12, 1'b1, 4'd1, 1'b1), 4'b0110, 5'h0, 1'b0); adv();
    cyc(dp(4'h0, 4'd4, 1'b0, 4'd2, 1'b1), 4'b0000, 5'h0, 1'b0); adv();
    cyc(NOP, 4'h0, M1M, 1'b0);
    chk("ne_skip", {29'b0, ForwardAE, MemWriteM}, 32'h0); adv();
    cyc(NOP, 4'h0, M1M, 1'b0);
    chk("flags_kept", {29'b0, ForwardAE, RegWriteW}, 32'h4); adv();
    nops(3);

    // Reset during a load-use stall clears everything, including Z
    cyc(dp(4'hE, 4'd2, 1'b1, 4'd0, 1'b0), 4'h0, 5'h0, 1'b0); adv();
    cyc(ldr(4'd2), 4'b0100, 5'h0, 1'b0); adv();
    cyc(dp(4'hE, 4'd4, 1'b0, 4'd3, 1'b0), 4'h0, M12, 1'b1);
    chk("pre_reset_stall", {31'b0, StallD}, 32'h1); adv();
    cyc(NOP, 4'h0, 5'h0, 1'b0); chk("post_reset", {11'b0, obs}, 32'h0); adv();
    cyc(dp(4'h0, 4'd4, 1'b0, 4'd1, 1'b1), 4'h0, 5'h0, 1'b0); adv();
    cyc(NOP, 4'h0, 5'h0, 1'b0); adv();
    cyc(NOP, 4'h0, M1M, 1'b0); chk("flags_cleared", {30'b0, ForwardAE}, 32'h0); adv();
    nops(3);

`ifdef BRANCH_EARLY_EN
    // SUBS R0,R0,R0 then BEQ: taken in E
    cyc(dp(4'hE, 4'd2, 1'b1, 4'd0, 1'b0), 4'h0, 5'h0, 1'b0); adv();
    cyc(br(4'h0), 4'b0110, 5'h0, 1'b0); adv();
    cyc(NOP, 4'h0, 5'h0, 1'b0);
    chk("beq_taken", {29'b0, BranchTakenE, FlushD, FlushE}, 32'h7); adv();
    nops(3);
    // ADDS with nonzero result then BEQ: not taken
    cyc(dp(4'hE, 4'd4, 1'b1, 4'd0, 1'b0), 4'h0, 5'h0, 1'b0); adv();
    cyc(br(4'h0), 4'b0000, 5'h0, 1'b0); adv();
    cyc(NOP, 4'h0, 5'h0, 1'b0);
    chk("beq_not_taken", {31'b0, BranchTakenE}, 32'h0); adv();
    nops(3);
`else
    // Taken branch behaves as a PC write resolved in W
    cyc(br(4'hE), 4'h0, 5'h0, 1'b0); adv();
    cyc(NOP, 4'h0, 5'h0, 1'b0);
    chk("b_in_e", {29'b0, BranchTakenE, StallF, FlushD}, 32'h3); adv();
    cyc(NOP, 4'h0, 5'h0, 1'b0); chk("b_in_m", {31'b0, StallF}, 32'h1); adv();
    cyc(NOP, 4'h0, 5'h0, 1'b0); chk("b_in_w", {30'b0, PCSrcW, FlushD}, 32'h3); adv();
    nops(2);
`endif

    // Randomized traffic against the model, with occasional resets
    for (int r = 0; r < 3000; r++) begin
      cyc(rnd_instr(), 4'($urandom), 5'($urandom), $urandom_range(0, 99) < 2);
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
